// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the serial parity frame checker.
// State encodings match PFC_IDLE=0, PFC_DATA=1, PFC_PAR=2 so benches can probe state.
package parity_frame_checker_pkg;

  typedef enum logic [1:0] {
    PFC_IDLE = 2'd0,
    PFC_DATA = 2'd1,
    PFC_PAR  = 2'd2
  } pfc_state_e;

  // Bit-index width; a one-bit frame still needs a one-bit index register.
  function automatic int pfc_idx_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// Combinational XOR reduction over N inputs; pure parity, no mode handling.
module parity_xor_tree #(
  parameter int N = 5
) (
  input  logic [N-1:0] bits,
  output logic         par
);

  assign par = ^bits;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: DATA_W data bits (LSB first) then one parity bit.
// Optional saturating error counter enabled by defining PFC_ERR_CNT_EN.
module parity_frame_checker
  import parity_frame_checker_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_vld,
  input  logic              frm_start,
  output logic [DATA_W-1:0] data_out,
  output logic              out_vld,
  output logic              pec,
  output logic              busy
`ifdef PFC_ERR_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int IDX_W = pfc_idx_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("parity_frame_checker: DATA_W and CNT_W must be >= 1");
  end

  pfc_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sreg;
  logic              xor_all;
  logic              par_err;

  // The incoming bit is the parity bit whenever a frame is in PAR.
  parity_xor_tree #(.N(DATA_W + 1)) u_xor (
    .bits ({bit_in, sreg}),
    .par  (xor_all)
  );

  assign par_err = xor_all ^ ODD_BIT;
  assign busy    = (state != PFC_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PFC_IDLE;
      idx      <= '0;
      sreg     <= '0;
      data_out <= '0;
      out_vld  <= 1'b0;
      pec      <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      if (bit_vld) begin
        // frm_start always wins: any frame in flight is dropped without a pulse
        if (frm_start) begin
          sreg[0] <= bit_in;
          if (LAST_IDX == '0) begin
            state <= PFC_PAR;
            idx   <= '0;
          end else begin
            state <= PFC_DATA;
            idx   <= IDX_W'(1);
          end
        end else begin
          case (state)
            PFC_DATA: begin
              sreg[idx] <= bit_in;
              if (idx == LAST_IDX) begin
                state <= PFC_PAR;
                idx   <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
            PFC_PAR: begin
              data_out <= sreg;
              pec      <= par_err;
              out_vld  <= 1'b1;
              state    <= PFC_IDLE;
            end
            default: begin
              state <= PFC_IDLE;
              idx   <= '0;
            end
          endcase
        end
      end
    end
  end

`ifdef PFC_ERR_CNT_EN
  logic frame_err;

  assign frame_err = bit_vld & ~frm_start & (state == PFC_PAR) & par_err;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized + directed bench for parity_frame_checker; an even and an odd instance
// share stimulus and are compared against a frame-level queue model.
module tb_parity_frame_checker;

  localparam int DW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst, bit_in, bit_vld, frm_start, cnt_clr;
  logic [DW-1:0] data_e, data_o;
  logic out_vld_e, out_vld_o, pec_e, pec_o, busy_e, busy_o;
  logic [CW-1:0] cnt_e, cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(DW), .ODD_PARITY(0), .CNT_W(CW)) dut_even (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .frm_start(frm_start),
    .data_out(data_e), .out_vld(out_vld_e), .pec(pec_e), .busy(busy_e)
`ifdef PFC_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .err_cnt(cnt_e)
`endif
  );

  parity_frame_checker #(.DATA_W(DW), .ODD_PARITY(1), .CNT_W(CW)) dut_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .frm_start(frm_start),
    .data_out(data_o), .out_vld(out_vld_o), .pec(pec_o), .busy(busy_o)
`ifdef PFC_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .err_cnt(cnt_o)
`endif
  );

`ifndef PFC_ERR_CNT_EN
  assign cnt_e = '0;
  assign cnt_o = '0;
`endif

  // Reference model: the bits of the frame in flight, plus held outputs.
  bit          q[$];
  bit          in_frame = 1'b0;
  bit          m_vld = 1'b0;
  bit [DW-1:0] m_data = '0;
  bit          m_pec_e = 1'b0;
  bit          m_pec_o = 1'b0;
  int          m_cnt_e = 0;
  int          m_cnt_o = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input bit b, input bit c);
    int ones;
    m_vld = 1'b0;
    if (r) begin
      q.delete();
      in_frame = 1'b0;
      m_data = '0;
      m_pec_e = 1'b0;
      m_pec_o = 1'b0;
      m_cnt_e = 0;
      m_cnt_o = 0;
      return;
    end
    if (v && s) begin
      q.delete();
      q.push_back(b);
      in_frame = 1'b1;
    end else if (v && in_frame) begin
      q.push_back(b);
    end
    if (in_frame && q.size() == DW + 1) begin
      ones = 0;
      foreach (q[i]) ones += int'(q[i]);
      for (int i = 0; i < DW; i++) m_data[i] = q[i];
      m_pec_e = (ones % 2) == 1;
      m_pec_o = (ones % 2) == 0;
      m_vld = 1'b1;
      in_frame = 1'b0;
      q.delete();
    end
    if (c) begin
      m_cnt_e = 0;
      m_cnt_o = 0;
    end else if (m_vld) begin
      if (m_pec_e && m_cnt_e < (1 << CW) - 1) m_cnt_e++;
      if (m_pec_o && m_cnt_o < (1 << CW) - 1) m_cnt_o++;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit b, input bit c);
    @(negedge clk);
    rst = r; bit_vld = v; frm_start = s; bit_in = b; cnt_clr = c;
    model(r, v, s, b, c);
    @(posedge clk);
    #1;
    check_val("out_vld_e", out_vld_e, m_vld);
    check_val("out_vld_o", out_vld_o, m_vld);
    check_val("busy_e", busy_e, in_frame);
    check_val("busy_o", busy_o, in_frame);
    check_val("data_e", data_e, m_data);
    check_val("data_o", data_o, m_data);
    check_val("pec_e", pec_e, m_pec_e);
    check_val("pec_o", pec_o, m_pec_o);
`ifdef PFC_ERR_CNT_EN
    check_val("cnt_e", cnt_e, m_cnt_e);
    check_val("cnt_o", cnt_o, m_cnt_o);
`endif
  endtask

  task automatic send_frame(input bit [DW-1:0] d, input bit p, input int gap, input bit clr_last);
    for (int i = 0; i < DW; i++) begin
      step(1'b0, 1'b1, i == 0, d[i], 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, p, clr_last);
  endtask

  initial begin
    rst = 1'b1; bit_vld = 1'b0; frm_start = 1'b0; bit_in = 1'b0; cnt_clr = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_busy", busy_e, 1'b0);
    check_val("reset_out_vld", out_vld_e, 1'b0);
    check_val("reset_data", data_e, 4'b0000);

    // bits 1,0,1,1 LSB first then parity 1: even frame is clean
    send_frame(4'b1101, 1'b1, 0, 1'b0);
    check_val("t1_vld", out_vld_e, 1'b1);
    check_val("t1_data", data_e, 4'b1101);
    check_val("t1_pec", pec_e, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t1_vld_drop", out_vld_e, 1'b0);
    check_val("t1_hold", data_e, 4'b1101);

    send_frame(4'b1101, 1'b0, 0, 1'b0);
    check_val("t2_pec", pec_e, 1'b1);
`ifdef PFC_ERR_CNT_EN
    check_val("t2_cnt", cnt_e, 2'd1);
`endif

    send_frame(4'b0000, 1'b1, 0, 1'b0);
    check_val("t3_pec_odd_ok", pec_o, 1'b0);
    send_frame(4'b0000, 1'b0, 0, 1'b0);
    check_val("t3_pec_odd_err", pec_o, 1'b1);

    send_frame(4'b1101, 1'b1, 3, 1'b0);
    check_val("t4_data", data_e, 4'b1101);
    check_val("t4_pec", pec_e, 1'b0);

    // abort after two bits; the restarting frame completes normally
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1, 1'b0);
    check_val("t5_data", data_e, 4'b0110);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_frame(4'($urandom_range(0, 15)), 1'b0, 0, 1'b0);
    end
`ifdef PFC_ERR_CNT_EN
    check_val("t6_sat", cnt_e, 2'd3);
    send_frame(4'b0001, 1'b0, 0, 1'b1);
    check_val("t6_clr_wins", cnt_e, 2'd0);
`endif

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("t7_rst_busy", busy_e, 1'b0);
    check_val("t7_rst_vld", out_vld_e, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("t7_stray_idle", busy_e, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      bit v, s, b, r, c;
      v = ($urandom % 4) != 0;
      s = v && (in_frame ? (($urandom % 16) == 0) : (($urandom % 3) == 0));
      b = 1'($urandom);
      r = ($urandom % 600) == 0;
      c = ($urandom % 50) == 0;
      step(r, v, s, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
